// File: rtl/fabric_tag_merge_pkg.sv
// Shared fabric definitions: elaboration error codes and index-width helper.
package fabric_tag_merge_pkg;

  localparam string ERR_NUM_IN     = "COMP_TAG_MERGE_NUM_IN";
  localparam string ERR_DATA_WIDTH = "COMP_TAG_MERGE_DATA_WIDTH";
  localparam string ERR_TAG_WIDTH  = "COMP_TAG_MERGE_TAG_WIDTH";

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fabric_tag_merge_arb.sv
// Round-robin arbiter: first requester at or after rr_ptr wins; pointer
// moves past the winner only when the grant is actually consumed.
module fabric_rr_arbiter
  import fabric_tag_merge_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = idx_w(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(NUM_IN);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_IN-1);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W:0]   cand;
  logic             found;

  // Wrapping search from rr_ptr; sum stays below 2*NUM_IN so one subtract wraps it.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
    grant[grant_idx] = found;
  end

  // Pointer advances to the slot after the channel that just transferred.
  always_ff @(posedge clk) begin
    if (rst)          rr_ptr <= '0;
    else if (advance) rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/fabric_tag_merge.sv
// Merges NUM_IN untagged streams into one tagged stream through a 2-entry
// FIFO; tags come from cfg_data at acceptance time. cfg_err flags duplicates.
module fabric_tag_merge
  import fabric_tag_merge_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_IN-1:0]                 in_valid,
  output logic [NUM_IN-1:0]                 in_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0]      in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0]   out_data,
  input  logic [NUM_IN*TAG_WIDTH-1:0]       cfg_data,
  output logic                              cfg_err
);

  localparam int CONFIG_WIDTH = NUM_IN*TAG_WIDTH;
  localparam int OUT_W        = DATA_WIDTH+TAG_WIDTH;
  localparam int IW           = idx_w(NUM_IN);

  if (NUM_IN < 2) begin : g_bad_num_in
    $fatal(1, "%s", ERR_NUM_IN);
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $fatal(1, "%s", ERR_DATA_WIDTH);
  end
  if (TAG_WIDTH < 1 || (TAG_WIDTH < 31 && (2**TAG_WIDTH) < NUM_IN)) begin : g_bad_tag_width
    $fatal(1, "%s", ERR_TAG_WIDTH);
  end

  logic [NUM_IN-1:0][TAG_WIDTH-1:0]  tags;
  logic [NUM_IN-1:0][DATA_WIDTH-1:0] chan;
  logic [NUM_IN-1:0]                 grant;
  logic [IW-1:0]                     grant_idx;
  logic [OUT_W-1:0]                  word;
  logic [1:0][OUT_W-1:0]             mem;
  logic                              wr_ptr, rd_ptr;
  logic [1:0]                        count;
  logic                              space, push, pop, dup;

  assign tags = cfg_data[CONFIG_WIDTH-1:0];
  assign chan = in_data;

  fabric_rr_arbiter #(.NUM_IN(NUM_IN), .IDX_W(IW)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (in_valid),
    .advance  (push),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Ready only for the granted channel with buffer room; a pop in the same
  // cycle does not open a slot, so a full FIFO never sees a push.
  assign space     = (count < 2'd2);
  assign in_ready  = (!rst && space) ? grant : '0;
  assign push      = |(in_valid & in_ready);
  assign pop       = out_valid && out_ready;
  assign word      = {tags[grant_idx], chan[grant_idx]};
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  // FIFO pointers and occupancy; reset drops anything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage captures the tag as configured in the accepting cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  // Pairwise tag compare across all channels.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_IN; i++)
      for (int j = i + 1; j < NUM_IN; j++)
        if (tags[i] == tags[j]) dup = 1'b1;
  end

  // Duplicate-tag flag, registered; informational only.
  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= dup;
  end

endmodule

// File: tb/tb_fabric_tag_merge.sv
// Bench for fabric_tag_merge: directed scenarios plus random traffic, all
// checked each cycle against a queue-based model of the merge.
module tb_fabric_tag_merge;

  localparam int NUM_IN = 4;
  localparam int DW     = 32;
  localparam int TW     = 4;
  localparam int OW     = DW + TW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_IN-1:0]    in_valid, in_ready;
  logic [NUM_IN*DW-1:0] in_data;
  logic                 out_valid, out_ready;
  logic [OW-1:0]        out_data;
  logic [NUM_IN*TW-1:0] cfg_data;
  logic                 cfg_err;

  fabric_tag_merge #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .cfg_data(cfg_data), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // model state
  logic [OW-1:0]        q[$];
  int                   ptr;
  bit                   err_m;
  logic [NUM_IN*TW-1:0] cfg;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit has_dup(input logic [NUM_IN*TW-1:0] c);
    for (int i = 0; i < NUM_IN; i++)
      for (int j = i + 1; j < NUM_IN; j++)
        if (c[i*TW +: TW] == c[j*TW +: TW]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NUM_IN*TW-1:0] mk_cfg(input int t0, t1, t2, t3);
    return {TW'(t3), TW'(t2), TW'(t1), TW'(t0)};
  endfunction

  // One clock: drive at negedge, check against model, then advance model at posedge.
  task automatic cyc(input logic r, input logic [NUM_IN-1:0] v, input logic ordy);
    int g;
    logic [NUM_IN-1:0] rdy_m;
    @(negedge clk);
    rst = r; in_valid = v; out_ready = ordy; cfg_data = cfg;
    for (int i = 0; i < NUM_IN; i++) in_data[i*DW +: DW] = $urandom;
    #1;
    g = -1;
    for (int k = 0; k < NUM_IN; k++) begin
      int idx;
      idx = (ptr + k) % NUM_IN;
      if (g < 0 && v[idx]) g = idx;
    end
    rdy_m = '0;
    if (!r && g >= 0 && q.size() < 2) rdy_m[g] = 1'b1;
    chk("in_ready", in_ready, rdy_m);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    chk("cfg_err", cfg_err, err_m);
    @(posedge clk);
    if (r) begin
      q.delete(); ptr = 0; err_m = 1'b0;
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (rdy_m != '0) begin
        q.push_back({cfg_data[g*TW +: TW], in_data[g*DW +: DW]});
        ptr = (g + 1) % NUM_IN;
      end
      err_m = has_dup(cfg_data);
    end
  endtask

  initial begin
    cfg = mk_cfg(3, 7, 1, 9);
    rst = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0; cfg_data = cfg;
    q.delete(); ptr = 0; err_m = 1'b0;
    repeat (2) @(posedge clk);

    // reset held with all channels requesting: nothing accepted
    cyc(1'b1, 4'hF, 1'b1);
    // streaming: tags 3,7,1,9,3,... one per cycle
    repeat (10) cyc(1'b0, 4'hF, 1'b1);
    repeat (3) cyc(1'b0, 4'h0, 1'b1);

    // lone channel 2
    cyc(1'b0, 4'b0100, 1'b1);
    repeat (2) cyc(1'b0, 4'h0, 1'b1);

    // backpressure: only two words accepted, then drain
    repeat (5) cyc(1'b0, 4'hF, 1'b0);
    repeat (4) cyc(1'b0, 4'h0, 1'b1);

    // tag change while a ch0 word is buffered
    cyc(1'b0, 4'b0001, 1'b0);
    cfg = mk_cfg(5, 7, 1, 9);
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0001, 1'b1);
    repeat (3) cyc(1'b0, 4'h0, 1'b1);

    // duplicate tags raise then clear cfg_err
    cfg = mk_cfg(2, 2, 4, 6);
    repeat (2) cyc(1'b0, 4'h0, 1'b1);
    cfg = mk_cfg(2, 3, 4, 6);
    repeat (2) cyc(1'b0, 4'h0, 1'b1);

    // reset with two words buffered, then restart at ch0
    repeat (3) cyc(1'b0, 4'hF, 1'b0);
    repeat (2) cyc(1'b1, 4'hF, 1'b0);
    repeat (4) cyc(1'b0, 4'hF, 1'b1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0)
        cfg = mk_cfg($urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15));
      cyc($urandom_range(0, 199) == 0, NUM_IN'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fabric_tag_merge.md
FABRIC_TAG_MERGE -- requirements
Module: fabric_tag_merge

Interface
REQ-001 Parameter NUM_IN, default 4: number of untagged input channels; SHALL be >= 2, else elaboration $fatal "COMP_TAG_MERGE_NUM_IN".
REQ-002 Parameter DATA_WIDTH, default 32: payload width; SHALL be >= 1, else $fatal "COMP_TAG_MERGE_DATA_WIDTH".
REQ-003 Parameter TAG_WIDTH, default 4: tag width; SHALL be >= 1 and 2**TAG_WIDTH >= NUM_IN, else $fatal "COMP_TAG_MERGE_TAG_WIDTH".
REQ-004 Localparam CONFIG_WIDTH = NUM_IN*TAG_WIDTH; localparam OUT_W = DATA_WIDTH+TAG_WIDTH.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  NUM_IN  per-channel valid.
REQ-008 in_ready  output  NUM_IN  per-channel ready.
REQ-009 in_data  input  NUM_IN*DATA_WIDTH  channel i payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 out_valid  output  1  tagged output valid.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 out_data  output  OUT_W  {tag, payload}, tag in MSBs.
REQ-013 cfg_data  input  CONFIG_WIDTH  tag for channel i at bits [i*TAG_WIDTH +: TAG_WIDTH].
REQ-014 cfg_err  output  1  registered flag: two or more channels configured with identical tags.

Function
REQ-015 Transfer on a port SHALL occur exactly when valid && ready are both high at a rising clk edge.
REQ-016 Arbiter SHALL grant one channel per cycle, round-robin: search starts at rr_ptr and wraps from NUM_IN-1 to 0; grant = first channel with in_valid high.
REQ-017 in_ready[i] SHALL be high only when i is granted and the output buffer has space (count < 2); all other in_ready bits low; in_ready SHALL NOT depend on in_valid of the granted channel beyond grant selection.
REQ-018 After an input transfer from channel g, rr_ptr SHALL become (g+1) mod NUM_IN; with no transfer rr_ptr holds.
REQ-019 Accepted word SHALL be {cfg_data tag of channel g sampled that cycle, payload}; later cfg_data changes SHALL NOT alter buffered words.
REQ-020 Output buffer: 2-entry FIFO; out_valid = (count != 0); out_data = head entry; latency input-transfer to out_valid = 1 cycle.
REQ-021 Sustained throughput SHALL be 1 word/cycle when out_ready held high.
REQ-022 Simultaneous push and pop: count unchanged, order preserved; push when count==2 SHALL NOT occur (in_ready low even if pop that cycle).
REQ-023 out_valid, once high, SHALL stay high with out_data stable until popped.
REQ-024 cfg_err SHALL be updated every cycle from a pairwise compare of all NUM_IN tags; one-cycle latency; no effect on dataflow.

Reset
REQ-025 While rst high at an edge: count=0, rr_ptr=0, cfg_err=0; hence out_valid=0 and in_ready=0 the cycle after.
REQ-026 Reset mid-operation SHALL discard buffered words without emitting them; inputs presented during reset SHALL NOT be accepted.

Structure
REQ-027 Error-code strings and a clog2-based index-width helper SHALL live in the shared fabric common package; no block-local typedefs exported.
REQ-028 Round-robin arbiter SHALL be a sub-module fabric_rr_arbiter (NUM_IN param; req, advance, grant one-hot, grant_idx); FIFO inline.

Verification
REQ-029 NUM_IN=4, tags {3,7,1,9}, all in_valid high, out_ready high -> out_data tags 3,7,1,9,3,... one per cycle, first out_valid 1 cycle after release of rst.
REQ-030 Only ch2 valid with payload 0xA5 -> out_data = {1,0xA5} next cycle; in_ready = 4'b0100 during request.
REQ-031 out_ready low for 5 cycles with all channels valid -> exactly 2 words accepted, then in_ready=0; on out_ready high, words drain in order with no loss or duplication.
REQ-032 Change ch0 tag 3->5 while ch0 word buffered -> buffered word emitted with tag 3; next ch0 word tag 5.
REQ-033 Tags {2,2,4,6} -> cfg_err=1 one cycle later; restore {2,3,4,6} -> cfg_err=0 one cycle later.
REQ-034 Assert rst with 2 words buffered -> next cycle out_valid=0, in_ready=0; after release, arbitration restarts at ch0.
